// File: rtl/heatmap_row_blitter.sv
// Captures one time step of grid colours and blits it as a ROW_H-pixel strip of a scrolling heat map.
// Define HEATMAP_CLEAR_EN to zero the whole frame buffer after every reset before the first step.
module heatmap_row_blitter #(
  parameter int unsigned NODES    = 64,
  parameter int unsigned SCALE    = 8,
  parameter int unsigned ROW_H    = 2,
  parameter int unsigned NUM_ROWS = 240,
  parameter int unsigned X_OFF    = 64,
  parameter int unsigned SCR_W    = 640,
  parameter int unsigned SCR_H    = 480
) (
  input  logic        clk_50,
  input  logic        reset,
  input  logic [7:0]  write_data,
  input  logic [7:0]  write_addr,
  input  logic        done_write_sig,
  input  logic        pause,
  input  logic        vga_ready,
  output logic        comp_allow,
  output logic        vga_we,
  output logic [18:0] vga_addr,
  output logic [7:0]  vga_data,
  output logic        row_done,
  output logic [7:0]  row_idx
);
  localparam int unsigned StripW = NODES * SCALE;
  localparam int unsigned XW     = $clog2(StripW);
  localparam int unsigned DyW    = (ROW_H > 1) ? $clog2(ROW_H) : 1;
  localparam int unsigned IdxW   = $clog2(NODES);
  localparam logic [18:0]   LineSkip = 19'(SCR_W - StripW + 1);
  localparam logic [XW-1:0] XLast    = XW'(StripW - 1);
  localparam logic [DyW-1:0] DyLast  = DyW'(ROW_H - 1);
  localparam logic [7:0]    RowLast  = 8'(NUM_ROWS - 1);

`ifdef HEATMAP_CLEAR_EN
  localparam logic [18:0] PixLast = 19'(SCR_W * SCR_H - 1);
  typedef enum logic [2:0] {StKick, StCapture, StDraw, StAdvance, StClear} state_t;
  localparam state_t StReset = StClear;
`else
  typedef enum logic [1:0] {StKick, StCapture, StDraw, StAdvance} state_t;
  localparam state_t StReset = StKick;
`endif

  state_t           r_state;
  logic             r_comp_allow, r_vga_we, r_row_done;
  logic [18:0]      r_vga_addr;
  logic [7:0]       r_vga_data, r_row_idx;
  logic [XW-1:0]    r_x;
  logic [DyW-1:0]   r_dy;
  logic [7:0]       r_line_buf [NODES];

  logic             w_buf_wr;
  logic [IdxW-1:0]  w_wr_idx;
  logic [7:0]       w_first_data, w_next_data;
  logic [XW-1:0]    w_x_next;
  logic [18:0]      w_row_base;

  assign w_buf_wr   = (r_state == StCapture) && (32'(write_addr) < NODES);
  assign w_wr_idx   = write_addr[IdxW-1:0];
  // The byte written in the done_write_sig cycle is not in the buffer yet; forward it.
  assign w_first_data = (w_buf_wr && (w_wr_idx == '0)) ? write_data : r_line_buf[0];
  assign w_x_next   = (r_x == XLast) ? '0 : r_x + XW'(1);
  assign w_next_data = r_line_buf[IdxW'(w_x_next / XW'(SCALE))];
  assign w_row_base = 19'(r_row_idx) * 19'(ROW_H * SCR_W) + 19'(X_OFF);

  always_ff @(posedge clk_50) begin
    if (w_buf_wr) r_line_buf[w_wr_idx] <= write_data;
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      r_state      <= StReset;
      r_comp_allow <= 1'b0;
      r_vga_we     <= 1'b0;
      r_vga_addr   <= '0;
      r_vga_data   <= '0;
      r_row_done   <= 1'b0;
      r_row_idx    <= '0;
      r_x          <= '0;
      r_dy         <= '0;
    end else begin
      r_comp_allow <= 1'b0;
      r_row_done   <= 1'b0;
      case (r_state)
`ifdef HEATMAP_CLEAR_EN
        StClear: begin
          if (!r_vga_we) begin
            r_vga_we   <= 1'b1;
            r_vga_addr <= '0;
            r_vga_data <= '0;
          end else if (vga_ready) begin
            if (r_vga_addr == PixLast) begin
              r_vga_we <= 1'b0;
              r_state  <= StKick;
            end else begin
              r_vga_addr <= r_vga_addr + 19'd1;
            end
          end
        end
`endif
        StKick: begin
          if (!pause) begin
            r_comp_allow <= 1'b1;
            r_state      <= StCapture;
          end
        end
        StCapture: begin
          if (done_write_sig) begin
            r_vga_we   <= 1'b1;
            r_vga_addr <= w_row_base;
            r_vga_data <= w_first_data;
            r_x        <= '0;
            r_dy       <= '0;
            r_state    <= StDraw;
          end
        end
        StDraw: begin
          if (vga_ready) begin
            if ((r_x == XLast) && (r_dy == DyLast)) begin
              r_vga_we <= 1'b0;
              r_state  <= StAdvance;
            end else begin
              r_x        <= w_x_next;
              r_vga_data <= w_next_data;
              if (r_x == XLast) begin
                r_dy       <= r_dy + DyW'(1);
                r_vga_addr <= r_vga_addr + LineSkip;
              end else begin
                r_vga_addr <= r_vga_addr + 19'd1;
              end
            end
          end
        end
        StAdvance: begin
          r_row_done <= 1'b1;
          r_row_idx  <= (r_row_idx == RowLast) ? '0 : r_row_idx + 8'd1;
          r_state    <= StKick;
        end
        default: r_state <= StReset;
      endcase
    end
  end

  assign comp_allow = r_comp_allow;
  assign vga_we     = r_vga_we;
  assign vga_addr   = r_vga_addr;
  assign vga_data   = r_vga_data;
  assign row_done   = r_row_done;
  assign row_idx    = r_row_idx;

endmodule

// File: tb/tb_heatmap_row_blitter.sv
// Randomised directed bench for heatmap_row_blitter (default build, HEATMAP_CLEAR_EN undefined).
// A short screen height keeps the row-wrap scenario within a small cycle budget.
module tb_heatmap_row_blitter;
  localparam int NODES  = 64;
  localparam int SCALE  = 8;
  localparam int ROW_H  = 2;
  localparam int X_OFF  = 64;
  localparam int SCR_W  = 640;
  localparam int STRIP  = NODES * SCALE;
  localparam int PIX    = STRIP * ROW_H;
  localparam int TbRows = 5;

  logic        clk_50 = 1'b0;
  logic        reset, done_write_sig, pause, vga_ready;
  logic [7:0]  write_data, write_addr;
  logic        comp_allow, vga_we, row_done;
  logic [18:0] vga_addr;
  logic [7:0]  vga_data, row_idx;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  ref_buf [NODES];
  int          ref_row;
  logic [18:0] obs_addr [PIX];
  logic [7:0]  obs_data [PIX];

  always #5 clk_50 = ~clk_50;

  heatmap_row_blitter #(.NUM_ROWS(TbRows)) dut (
    .clk_50        (clk_50),
    .reset         (reset),
    .write_data    (write_data),
    .write_addr    (write_addr),
    .done_write_sig(done_write_sig),
    .pause         (pause),
    .vga_ready     (vga_ready),
    .comp_allow    (comp_allow),
    .vga_we        (vga_we),
    .vga_addr      (vga_addr),
    .vga_data      (vga_data),
    .row_done      (row_done),
    .row_idx       (row_idx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Presents every node once (4-cycle hold), some out-of-range writes, then the done cycle.
  task automatic capture(input bit ident, input int done_addr);
    int quiet_bad = 0;
    for (int a = 0; a < NODES; a++) begin
      write_addr = 8'(a);
      write_data = ident ? 8'(a) : 8'($urandom);
      ref_buf[a] = write_data;
      repeat (4) begin
        @(negedge clk_50);
        if (vga_we !== 1'b0 || comp_allow !== 1'b0) quiet_bad++;
      end
    end
    if (!ident) begin
      for (int i = 0; i < 6; i++) begin
        write_addr = 8'($urandom_range(NODES, 255));
        write_data = 8'($urandom);
        @(negedge clk_50);
      end
    end
    write_addr = 8'(done_addr);
    write_data = 8'($urandom);
    done_write_sig = 1'b1;
    if (done_addr < NODES) ref_buf[done_addr] = write_data;
    @(negedge clk_50);
    done_write_sig = 1'b0;
    check("capture_quiet", quiet_bad, 0);
  endtask

  // Consumes max_pix accepted pixels; returns at the negedge before the last accepting edge.
  task automatic draw_row(input bit stall, input int max_pix);
    int k = 0, iters = 0, bad = 0, hold_bad = 0;
    logic pw = 1'b0, pr = 1'b0;
    logic [18:0] pa = '0;
    logic [7:0] pd = '0, ed;
    int unsigned ea;
    while (k < max_pix && iters < 8000) begin
      if (pw && !pr && (vga_we !== 1'b1 || vga_addr !== pa || vga_data !== pd)) hold_bad++;
      if (stall) vga_ready = (iters >= 200 && iters < 205) ? 1'b0 : ($urandom_range(0, 3) != 0);
      else vga_ready = 1'b1;
      write_addr = 8'($urandom_range(0, NODES - 1));
      write_data = 8'($urandom);
      done_write_sig = 1'($urandom_range(0, 1));
      if (vga_we === 1'b1 && vga_ready) begin
        ea = 32'((ref_row * ROW_H + k / STRIP) * SCR_W + X_OFF + k % STRIP);
        ed = ref_buf[(k % STRIP) / SCALE];
        obs_addr[k] = vga_addr;
        obs_data[k] = vga_data;
        if (vga_addr !== 19'(ea) || vga_data !== ed) bad++;
        k++;
      end
      pw = vga_we; pr = vga_ready; pa = vga_addr; pd = vga_data;
      iters++;
      if (k < max_pix) @(negedge clk_50);
    end
    check("draw_count", k, max_pix);
    check("draw_pixel_errors", bad, 0);
    if (stall) check("stall_hold_errors", hold_bad, 0);
    else if (max_pix == PIX) check("draw_cycles", iters, PIX);
  endtask

  task automatic finish_row(input bit do_pause);
    int paused_bad = 0;
    int nxt = (ref_row + 1) % TbRows;
    done_write_sig = 1'b0;
    vga_ready = 1'b1;
    @(negedge clk_50);
    check("adv_we_low", vga_we, 0);
    check("adv_row_done_wait", row_done, 0);
    if (do_pause) pause = 1'b1;
    @(negedge clk_50);
    check("row_done_pulse", row_done, 1);
    check("row_idx_next", row_idx, nxt);
    check("no_early_kick", comp_allow, 0);
    @(negedge clk_50);
    check("row_done_once", row_done, 0);
    if (do_pause) begin
      repeat (4) begin
        if (comp_allow !== 1'b0) paused_bad++;
        @(negedge clk_50);
      end
      check("pause_holds", paused_bad, 0);
      pause = 1'b0;
      @(negedge clk_50);
    end
    check("comp_allow_pulse", comp_allow, 1);
    ref_row = nxt;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; pause = 1'b0; vga_ready = 1'b0; done_write_sig = 1'b0;
    write_addr = '0; write_data = '0; ref_row = 0;
    repeat (3) @(negedge clk_50);
    check("rst_ctl", {comp_allow, vga_we, row_done}, 0);
    check("rst_addr", vga_addr, 0);
    check("rst_data_row", {vga_data, row_idx}, 0);
    reset = 1'b0;
    @(negedge clk_50);
    check("first_kick", comp_allow, 1);
    @(negedge clk_50);
    check("kick_once", comp_allow, 0);
    check("row_idx_start", row_idx, 0);

    // Step 1: data = address, fixed spot pixels.
    capture(1'b1, 200);
    draw_row(1'b0, PIX);
    check("s1_a0", obs_addr[0], 64);    check("s1_d0", obs_data[0], 0);
    check("s1_a7", obs_addr[7], 71);    check("s1_d7", obs_data[7], 0);
    check("s1_a8", obs_addr[8], 72);    check("s1_d8", obs_data[8], 1);
    check("s1_a511", obs_addr[511], 575); check("s1_d511", obs_data[511], 63);
    check("s1_a512", obs_addr[512], 704); check("s1_d512", obs_data[512], 0);
    finish_row(1'b0);

    // Step 2: random back-pressure plus a forced 5-cycle stall, then a paused kick.
    capture(1'b0, $urandom_range(0, 255));
    draw_row(1'b1, PIX);
    finish_row(1'b1);

    // Steps 3..6: reach the last row and wrap back to row 0.
    for (int s = 3; s <= 6; s++) begin
      capture(1'b0, (s == 3) ? 0 : $urandom_range(0, 255));
      if (s == 6) check("wrap_row_idx", row_idx, 0);
      draw_row(1'b0, PIX);
      if (ref_row == TbRows - 1)
        check("last_row_base", obs_addr[0], (TbRows - 1) * ROW_H * SCR_W + X_OFF);
      if (s == 6) check("wrap_base", obs_addr[0], X_OFF);
      finish_row(1'b0);
    end

    // Reset mid-draw: outputs drop without a clock edge, then restart at row 0.
    capture(1'b0, $urandom_range(0, 255));
    draw_row(1'b0, 300);
    #2 reset = 1'b1;
    #1;
    check("rst_async_we", vga_we, 0);
    check("rst_async_addr", vga_addr, 0);
    check("rst_async_row", row_idx, 0);
    done_write_sig = 1'b0;
    vga_ready = 1'b1;
    @(negedge clk_50);
    @(negedge clk_50);
    reset = 1'b0;
    ref_row = 0;
    @(negedge clk_50);
    check("post_rst_kick", comp_allow, 1);

    capture(1'b0, 0);
    draw_row(1'b0, PIX);
    finish_row(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
